// File: rtl/pi_loop_scheduler.sv
// Sequences one shared PI engine across the speed, iq and id FOC loops each control tick.
// Optional PI_SCHED_TIMEOUT_EN adds a bounded wait on pi_done with a sticky timeout flag.
module pi_loop_scheduler #(
  parameter int N         = 10,
  parameter int F         = 9,
  parameter int SPEED_DIV = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         tick,
  input  logic         clr_flags,
  input  logic [N-1:0] speed_ref,
  input  logic [N-1:0] speed,
  input  logic [N-1:0] id_ref,
  input  logic [N-1:0] id_meas,
  input  logic [N-1:0] iq_meas,
  output logic         pi_start,
  output logic [1:0]   pi_loop,
  output logic [N-1:0] pi_ref,
  output logic [N-1:0] pi_fb,
  input  logic [N-1:0] pi_y,
  input  logic         pi_done,
  output logic [N-1:0] torque_ref,
  output logic [N-1:0] vq_ref,
  output logic [N-1:0] vd_ref,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun,
  output logic         timeout
);

  if (F < 0 || F >= N) begin : g_bad_frac
    $error("pi_loop_scheduler: F must lie in [0, N-1]");
  end
  if (SPEED_DIV < 1) begin : g_bad_div
    $error("pi_loop_scheduler: SPEED_DIV must be >= 1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("pi_loop_scheduler: TIMEOUT must be >= 2");
  end

  localparam int DW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;

  localparam logic [1:0] LOOP_SPD = 2'd0;
  localparam logic [1:0] LOOP_IQ  = 2'd1;
  localparam logic [1:0] LOOP_ID  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPD_REQ,
    S_SPD_WAIT,
    S_IQ_REQ,
    S_IQ_WAIT,
    S_ID_REQ,
    S_ID_WAIT,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [1:0]     loop_q, loop_d;
  logic [N-1:0]   ref_q, ref_d;
  logic [N-1:0]   fb_q, fb_d;
  logic [N-1:0]   torque_q, torque_d;
  logic [N-1:0]   vq_q, vq_d;
  logic [N-1:0]   vd_q, vd_d;
  logic           overrun_q, overrun_d;
  logic           timeout_q, timeout_d;
  logic           in_req, in_wait;

  assign in_req  = (state_q == S_SPD_REQ) || (state_q == S_IQ_REQ) || (state_q == S_ID_REQ);
  assign in_wait = (state_q == S_SPD_WAIT) || (state_q == S_IQ_WAIT) || (state_q == S_ID_WAIT);

`ifdef PI_SCHED_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT);
  logic [WCW-1:0] wait_q, wait_d;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    loop_d    = loop_q;
    ref_d     = ref_q;
    fb_d      = fb_q;
    torque_d  = torque_q;
    vq_d      = vq_q;
    vd_d      = vd_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;

    // Clear first so a coincident set below wins.
    if (clr_flags) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
    if (tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tick && enable) begin
          div_d = (div_q == DW'(SPEED_DIV - 1)) ? '0 : div_q + DW'(1);
          if (div_q == '0) begin
            state_d = S_SPD_REQ;
            loop_d  = LOOP_SPD;
            ref_d   = speed_ref;
            fb_d    = speed;
          end else begin
            state_d = S_IQ_REQ;
            loop_d  = LOOP_IQ;
            ref_d   = torque_q;
            fb_d    = iq_meas;
          end
        end
      end
      S_SPD_REQ: state_d = S_SPD_WAIT;
      S_SPD_WAIT: begin
        if (pi_done) begin
          // iq reference takes the torque result being latched on this same edge.
          torque_d = pi_y;
          state_d  = S_IQ_REQ;
          loop_d   = LOOP_IQ;
          ref_d    = pi_y;
          fb_d     = iq_meas;
        end
      end
      S_IQ_REQ: state_d = S_IQ_WAIT;
      S_IQ_WAIT: begin
        if (pi_done) begin
          vq_d    = pi_y;
          state_d = S_ID_REQ;
          loop_d  = LOOP_ID;
          ref_d   = id_ref;
          fb_d    = id_meas;
        end
      end
      S_ID_REQ: state_d = S_ID_WAIT;
      S_ID_WAIT: begin
        if (pi_done) begin
          vd_d    = pi_y;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef PI_SCHED_TIMEOUT_EN
    wait_d = wait_q;
    if (in_req) begin
      wait_d = '0;
    end else if (in_wait) begin
      wait_d = wait_q + WCW'(1);
      // wait_q counts WAIT cycles minus one, so the flag lands TIMEOUT cycles after pi_start.
      if (!pi_done && (wait_q == WCW'(TIMEOUT - 2))) begin
        timeout_d = 1'b1;
        state_d   = S_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      loop_q    <= '0;
      ref_q     <= '0;
      fb_q      <= '0;
      torque_q  <= '0;
      vq_q      <= '0;
      vd_q      <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      loop_q    <= loop_d;
      ref_q     <= ref_d;
      fb_q      <= fb_d;
      torque_q  <= torque_d;
      vq_q      <= vq_d;
      vd_q      <= vd_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef PI_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign pi_start   = in_req;
  assign pi_loop    = loop_q;
  assign pi_ref     = ref_q;
  assign pi_fb      = fb_q;
  assign torque_ref = torque_q;
  assign vq_ref     = vq_q;
  assign vd_ref     = vd_q;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pi_loop_scheduler.sv
// Directed bench for pi_loop_scheduler: cycle table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_pi_loop_scheduler;
  localparam int N = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, enable, clr_flags, tick_a, tick_b;
  logic [N-1:0] speed_ref, speed, id_ref, id_meas, iq_meas;

  logic         pi_start_a, pi_done_a, out_valid_a, busy_a, overrun_a, timeout_a;
  logic [1:0]   pi_loop_a;
  logic [N-1:0] pi_ref_a, pi_fb_a, pi_y_a, torque_a, vq_a, vd_a;

  logic         pi_start_b, pi_done_b, out_valid_b, busy_b, overrun_b, timeout_b;
  logic [1:0]   pi_loop_b;
  logic [N-1:0] pi_ref_b, pi_fb_b, pi_y_b, torque_b, vq_b, vd_b;

  int checks = 0;
  int errors = 0;
  int lat_a  = 1;
  int lat_b  = 3;
  bit done_en_a = 1'b1;

  pi_loop_scheduler #(.N(N), .F(9), .SPEED_DIV(8), .TIMEOUT(64)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick_a), .clr_flags(clr_flags),
    .speed_ref(speed_ref), .speed(speed), .id_ref(id_ref), .id_meas(id_meas), .iq_meas(iq_meas),
    .pi_start(pi_start_a), .pi_loop(pi_loop_a), .pi_ref(pi_ref_a), .pi_fb(pi_fb_a),
    .pi_y(pi_y_a), .pi_done(pi_done_a), .torque_ref(torque_a), .vq_ref(vq_a), .vd_ref(vd_a),
    .out_valid(out_valid_a), .busy(busy_a), .overrun(overrun_a), .timeout(timeout_a)
  );

  pi_loop_scheduler #(.N(N), .F(9), .SPEED_DIV(1), .TIMEOUT(64)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick_b), .clr_flags(clr_flags),
    .speed_ref(speed_ref), .speed(speed), .id_ref(id_ref), .id_meas(id_meas), .iq_meas(iq_meas),
    .pi_start(pi_start_b), .pi_loop(pi_loop_b), .pi_ref(pi_ref_b), .pi_fb(pi_fb_b),
    .pi_y(pi_y_b), .pi_done(pi_done_b), .torque_ref(torque_b), .vq_ref(vq_b), .vd_ref(vd_b),
    .out_valid(out_valid_b), .busy(busy_b), .overrun(overrun_b), .timeout(timeout_b)
  );

  // Echo engines: pi_done lands lat cycles after pi_start, result = captured pi_ref.
  initial begin
    int cnt;
    logic [N-1:0] cap;
    cnt = 0; cap = '0; pi_done_a = 1'b0; pi_y_a = '0;
    forever begin
      @(posedge clk); #1;
      pi_done_a = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && done_en_a) begin
          pi_done_a = 1'b1;
          pi_y_a = cap;
        end
      end
      if (pi_start_a) begin
        cnt = lat_a;
        cap = pi_ref_a;
      end
    end
  end

  initial begin
    int cnt;
    logic [N-1:0] cap;
    cnt = 0; cap = '0; pi_done_b = 1'b0; pi_y_b = '0;
    forever begin
      @(posedge clk); #1;
      pi_done_b = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          pi_done_b = 1'b1;
          pi_y_b = cap;
        end
      end
      if (pi_start_b) begin
        cnt = lat_b;
        cap = pi_ref_b;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic chk_zero_a(input string nm);
    chk({nm, " regs"}, {2'b0, torque_a, vq_a, vd_a}, 32'h0);
    chk({nm, " ctl"}, {5'b0, pi_loop_a, pi_ref_a, pi_fb_a, pi_start_a, out_valid_a,
                       busy_a, overrun_a, timeout_a}, 32'h0);
  endtask

  // Called in an idle cycle; returns in the first idle cycle after out_valid.
  task automatic run_a(input bit spd, input int lat, input string nm);
    int n;
    bit seen;
    tick_a = 1'b1;
    step();
    tick_a = 1'b0;
    chk({nm, " req"}, 32'({pi_start_a, pi_loop_a}), 32'({1'b1, spd ? 2'd0 : 2'd1}));
    n = 1; seen = 1'b0;
    while (!seen && n < 200) begin
      if (out_valid_a) seen = 1'b1;
      else begin step(); n++; end
    end
    chk({nm, " latency"}, 32'(n), 32'(1 + (spd ? 3 : 2) * (lat + 1)));
    step();
  endtask

  typedef struct {
    logic [2:0] in;   // tick, enable, clr_flags
    logic [9:0] idr;
    logic [3:0] ctl;  // pi_start, out_valid, busy, overrun
    logic [1:0] lp;
    logic [9:0] rf, fb, tq, vq, vd;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{3'b110, 10'h033, 4'b0000, 2'd0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    tbl[1]  = '{3'b010, 10'h033, 4'b1010, 2'd0, 10'h100, 10'h011, 10'h000, 10'h000, 10'h000};
    tbl[2]  = '{3'b010, 10'h033, 4'b0010, 2'd0, 10'h100, 10'h011, 10'h000, 10'h000, 10'h000};
    tbl[3]  = '{3'b010, 10'h033, 4'b1010, 2'd1, 10'h100, 10'h022, 10'h100, 10'h000, 10'h000};
    tbl[4]  = '{3'b010, 10'h033, 4'b0010, 2'd1, 10'h100, 10'h022, 10'h100, 10'h000, 10'h000};
    tbl[5]  = '{3'b010, 10'h033, 4'b1010, 2'd2, 10'h033, 10'h044, 10'h100, 10'h100, 10'h000};
    tbl[6]  = '{3'b010, 10'h033, 4'b0010, 2'd2, 10'h033, 10'h044, 10'h100, 10'h100, 10'h000};
    tbl[7]  = '{3'b010, 10'h033, 4'b0110, 2'd0, 10'h000, 10'h000, 10'h100, 10'h100, 10'h033};
    tbl[8]  = '{3'b110, 10'h0AA, 4'b0000, 2'd0, 10'h000, 10'h000, 10'h100, 10'h100, 10'h033};
    tbl[9]  = '{3'b010, 10'h0AA, 4'b1010, 2'd1, 10'h100, 10'h022, 10'h100, 10'h100, 10'h033};
    tbl[10] = '{3'b010, 10'h0AA, 4'b0010, 2'd1, 10'h100, 10'h022, 10'h100, 10'h100, 10'h033};
    tbl[11] = '{3'b110, 10'h0AA, 4'b1010, 2'd2, 10'h0AA, 10'h044, 10'h100, 10'h100, 10'h033};
    tbl[12] = '{3'b010, 10'h0AA, 4'b0011, 2'd2, 10'h0AA, 10'h044, 10'h100, 10'h100, 10'h033};
    tbl[13] = '{3'b010, 10'h0AA, 4'b0111, 2'd0, 10'h000, 10'h000, 10'h100, 10'h100, 10'h0AA};
    tbl[14] = '{3'b011, 10'h0AA, 4'b0001, 2'd0, 10'h000, 10'h000, 10'h100, 10'h100, 10'h0AA};
    tbl[15] = '{3'b010, 10'h0AA, 4'b0000, 2'd0, 10'h000, 10'h000, 10'h100, 10'h100, 10'h0AA};
    tbl[16] = '{3'b100, 10'h0AA, 4'b0000, 2'd0, 10'h000, 10'h000, 10'h100, 10'h100, 10'h0AA};
    tbl[17] = '{3'b010, 10'h0AA, 4'b0000, 2'd0, 10'h000, 10'h000, 10'h100, 10'h100, 10'h0AA};

    rst_n = 1'b0; enable = 1'b0; clr_flags = 1'b0; tick_a = 1'b0; tick_b = 1'b0;
    speed_ref = 10'h100; speed = 10'h011; iq_meas = 10'h022;
    id_ref = 10'h033; id_meas = 10'h044;
    step(); step();
    chk_zero_a("reset_a");
    chk("reset_b", {2'b0, torque_b, vq_b, vd_b}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step();
      chk($sformatf("row%0d ctl", i),
          32'({pi_start_a, out_valid_a, busy_a, overrun_a, timeout_a}), 32'({tbl[i].ctl, 1'b0}));
      if (tbl[i].ctl[1] && !tbl[i].ctl[2])
        chk($sformatf("row%0d operands", i), 32'({pi_loop_a, pi_ref_a, pi_fb_a}),
            32'({tbl[i].lp, tbl[i].rf, tbl[i].fb}));
      chk($sformatf("row%0d outregs", i), 32'({torque_a, vq_a, vd_a}),
          32'({tbl[i].tq, tbl[i].vq, tbl[i].vd}));
      {tick_a, enable, clr_flags} = tbl[i].in;
      id_ref = tbl[i].idr;
    end

    // Accepted ticks so far: 2. Six more skip speed, the ninth wraps the divider.
    for (int t = 0; t < 6; t++) run_a(1'b0, 1, $sformatf("div_tick%0d", t + 3));
    speed_ref = 10'h055;
    run_a(1'b1, 1, "div_wrap");
    chk("wrap torque", 32'({torque_a, vq_a}), 32'({10'h055, 10'h055}));

    // Overrun coinciding with clr_flags: set wins.
    tick_a = 1'b1; step(); tick_a = 1'b0; step(); step();
    tick_a = 1'b1; clr_flags = 1'b1; step();
    tick_a = 1'b0; clr_flags = 1'b0;
    chk("ovr_set_wins", 32'(overrun_a), 32'h1);
    begin
      int n = 4;
      while (!out_valid_a && n < 200) begin step(); n++; end
      chk("ovr_seq latency", 32'(n), 32'h5);
    end
    step();
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    chk("ovr_clear", 32'(overrun_a), 32'h0);

    // enable dropped at cycle 2 still completes the sequence.
    tick_a = 1'b1; step(); tick_a = 1'b0; step();
    enable = 1'b0;
    begin
      int n = 2;
      while (!out_valid_a && n < 200) begin step(); n++; end
      chk("en_drop latency", 32'(n), 32'h5);
    end
    step();
    tick_a = 1'b1; step(); tick_a = 1'b0;
    begin
      bit act = 1'b0;
      for (int c = 0; c < 4; c++) begin act |= busy_a | pi_start_a; step(); end
      chk("disabled no start", 32'(act), 32'h0);
    end
    enable = 1'b1;

`ifdef PI_SCHED_TIMEOUT_EN
    begin
      logic [N-1:0] vq_prev;
      bit seen_valid;
      vq_prev = vq_a;
      seen_valid = 1'b0;
      tick_a = 1'b1; step(); tick_a = 1'b0;
      done_en_a = 1'b0;
      chk("to iq start", 32'({pi_start_a, pi_loop_a}), 32'({1'b1, 2'd1}));
      for (int c = 2; c <= 64; c++) begin step(); seen_valid |= out_valid_a; end
      chk("to before", 32'({timeout_a, busy_a}), 32'b01);
      step(); seen_valid |= out_valid_a;
      chk("to flag", 32'({timeout_a, busy_a, seen_valid}), 32'b100);
      chk("to vq held", 32'(vq_a), 32'(vq_prev));
      done_en_a = 1'b1;
      step(); step();
    end
`endif

    // Asynchronous reset in IQ_WAIT; the engine's late pi_done must be ignored.
    lat_a = 4;
    tick_a = 1'b1; step(); tick_a = 1'b0;
    step();
    chk("pre_rst", 32'({busy_a, pi_loop_a, vq_a}), 32'({1'b1, 2'd1, 10'h055}));
    #1 rst_n = 1'b0;
    #1 chk_zero_a("async_rst");
    step();
    rst_n = 1'b1;
    begin
      bit act = 1'b0;
      for (int c = 0; c < 5; c++) begin step(); act |= busy_a | out_valid_a | (vq_a != '0); end
      chk("late_done ignored", 32'(act), 32'h0);
    end
    lat_a = 1;
    run_a(1'b1, 1, "post_rst");
    chk("post_rst torque", 32'(torque_a), 32'h055);

    // SPEED_DIV=1, L=3: every tick runs all three loops.
    for (int k = 0; k < 2; k++) begin
      int n;
      tick_b = 1'b1; step(); tick_b = 1'b0;
      chk($sformatf("b%0d req", k), 32'({pi_start_b, pi_loop_b}), 32'({1'b1, 2'd0}));
      n = 1;
      while (!out_valid_b && n < 200) begin step(); n++; end
      chk($sformatf("b%0d latency", k), 32'(n), 32'd13);
      step();
    end
    chk("b vd", 32'(vd_b), 32'h0AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
